// File: rtl/scene_pkg.sv
// Shared types for the scene loader path between the XMODEM receiver and SDRAM.
package scene_pkg;

    typedef logic [31:0] scene_word_t;

    typedef enum logic [1:0] {
        SL_IDLE,
        SL_LOAD,
        SL_FLUSH,
        SL_DONE
    } sl_state_t;

    localparam int unsigned XMODEM_BLK_BYTES = 128;

endpackage

// File: rtl/sl_word_fifo.sv
// Synchronous word FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sl_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scene_byte_packer.sv
// Packs validated XMODEM scene bytes little-endian into 32-bit words and streams them
// to the SDRAM write port, checking block sequencing and signalling completion.
module scene_byte_packer
    import scene_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 25,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter int unsigned        FIFO_DEPTH = 8,
    parameter int unsigned        BLK_W      = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [7:0]        xmodem_data_byte,
    input  logic              xmodem_saw_valid_msg_byte,
    input  logic              xmodem_saw_valid_block,
    input  logic [BLK_W-1:0]  sl_block_num,
    input  logic              xmodem_done,
    output logic              sl_wr_valid,
    output logic [ADDR_W-1:0] sl_wr_addr,
    output logic [31:0]       sl_wr_data,
    input  logic              sl_wr_stall,
    output logic              sl_done,
    output logic [ADDR_W-1:0] sl_num_words,
    output logic              sl_seq_err,
    output logic              sl_ovf_err
);

    sl_state_t                   state;
    logic [1:0]                  lane;
    logic [1:0]                  lane_after;
    scene_word_t                 acc;
    scene_word_t                 merged;
    scene_word_t                 stage_word;
    logic                        stage_valid;
    logic                        stage_load;
    logic [BLK_W-1:0]            exp_blk;
    logic [BLK_W-1:0]            exp_cur;
    logic                        byte_ok;
    logic                        start;
    logic                        flush_now;
    logic                        blk_hit;
    logic                        blk_bad;
    logic                        pop;
    logic                        ovf_evt;
    scene_word_t                 head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign byte_ok    = xmodem_saw_valid_msg_byte && (state == SL_IDLE || state == SL_LOAD);
    assign start      = byte_ok && (state == SL_IDLE);
    assign flush_now  = xmodem_done && (state == SL_LOAD);
    // acc holds zeros above the current lane, so OR-ing in the byte zero-pads a partial word.
    assign merged     = byte_ok ? (acc | (scene_word_t'(xmodem_data_byte) << {lane, 3'b000})) : acc;
    assign lane_after = byte_ok ? lane + 2'd1 : lane;
    assign stage_load = (byte_ok && lane == 2'd3) || (flush_now && lane_after != 2'd0);

    assign exp_cur    = (state == SL_IDLE) ? '0 : exp_blk;
    assign blk_hit    = byte_ok && xmodem_saw_valid_block;
    assign blk_bad    = blk_hit && (sl_block_num != exp_cur);

    assign pop        = !fifo_empty && !sl_wr_stall;
    assign ovf_evt    = stage_valid && fifo_full && !pop;

    assign sl_wr_valid = !fifo_empty;
    assign sl_wr_data  = fifo_empty ? '0 : head;

    sl_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (stage_valid),
        .push_data (stage_word),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= SL_IDLE;
            lane         <= '0;
            acc          <= '0;
            stage_word   <= '0;
            stage_valid  <= 1'b0;
            exp_blk      <= '0;
            sl_wr_addr   <= BASE_ADDR;
            sl_num_words <= '0;
            sl_seq_err   <= 1'b0;
            sl_ovf_err   <= 1'b0;
            sl_done      <= 1'b0;
        end else begin
            stage_valid <= stage_load;
            if (stage_load) begin
                stage_word <= merged;
                acc        <= '0;
                lane       <= '0;
            end else if (byte_ok) begin
                acc  <= merged;
                lane <= lane_after;
            end

            if (blk_hit) begin
                exp_blk <= exp_cur + 1'b1;
            end else if (start) begin
                exp_blk <= '0;
            end

            if (start) begin
                sl_seq_err <= blk_bad;
                sl_ovf_err <= 1'b0;
            end else begin
                if (blk_bad) sl_seq_err <= 1'b1;
                if (ovf_evt) sl_ovf_err <= 1'b1;
            end

            if (start) begin
                sl_wr_addr   <= BASE_ADDR;
                sl_num_words <= '0;
            end else if (pop) begin
                sl_wr_addr   <= sl_wr_addr + 1'b1;
                sl_num_words <= sl_num_words + 1'b1;
            end

            case (state)
                SL_IDLE: begin
                    sl_done <= 1'b0;
                    if (byte_ok) state <= SL_LOAD;
                end
                SL_LOAD: begin
                    if (xmodem_done) state <= SL_FLUSH;
                end
                SL_FLUSH: begin
                    if (!stage_valid && fifo_count == '0) begin
                        state   <= SL_DONE;
                        sl_done <= 1'b1;
                    end
                end
                default: begin
                    sl_done <= 1'b0;
                    state   <= SL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scene_byte_packer.sv
// Directed bench for scene_byte_packer: a negedge monitor logs every accepted write.
module tb_scene_byte_packer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [7:0]  xmodem_data_byte;
    logic        xmodem_saw_valid_msg_byte;
    logic        xmodem_saw_valid_block;
    logic [7:0]  sl_block_num;
    logic        xmodem_done;
    logic        sl_wr_valid;
    logic [24:0] sl_wr_addr;
    logic [31:0] sl_wr_data;
    logic        sl_wr_stall;
    logic        sl_done;
    logic [24:0] sl_num_words;
    logic        sl_seq_err;
    logic        sl_ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] mon_addr [512];
    logic [31:0] mon_data [512];
    int          wr_total   = 0;
    int          done_total = 0;
    int          stab_err   = 0;
    logic        prev_hold  = 1'b0;
    logic [24:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    always #5 clk = ~clk;

    scene_byte_packer #(
        .ADDR_W     (25),
        .BASE_ADDR  (25'h0),
        .FIFO_DEPTH (8),
        .BLK_W      (8)
    ) dut (
        .clk                       (clk),
        .rst_b                     (rst_b),
        .xmodem_data_byte          (xmodem_data_byte),
        .xmodem_saw_valid_msg_byte (xmodem_saw_valid_msg_byte),
        .xmodem_saw_valid_block    (xmodem_saw_valid_block),
        .sl_block_num              (sl_block_num),
        .xmodem_done               (xmodem_done),
        .sl_wr_valid               (sl_wr_valid),
        .sl_wr_addr                (sl_wr_addr),
        .sl_wr_data                (sl_wr_data),
        .sl_wr_stall               (sl_wr_stall),
        .sl_done                   (sl_done),
        .sl_num_words              (sl_num_words),
        .sl_seq_err                (sl_seq_err),
        .sl_ovf_err                (sl_ovf_err)
    );

    // Inputs change 1ns after posedge, so negedge values are what the next posedge sees.
    always @(negedge clk) begin
        if (sl_done) done_total++;
        if (prev_hold && sl_wr_valid && (sl_wr_data !== prev_data || sl_wr_addr !== prev_addr))
            stab_err++;
        prev_hold = sl_wr_valid && sl_wr_stall;
        prev_data = sl_wr_data;
        prev_addr = sl_wr_addr;
        if (sl_wr_valid && !sl_wr_stall) begin
            if (wr_total < 512) begin
                mon_addr[wr_total] = sl_wr_addr;
                mon_data[wr_total] = sl_wr_data;
            end
            wr_total++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic blk, input logic [7:0] num);
        xmodem_data_byte          = b;
        xmodem_saw_valid_msg_byte = 1'b1;
        xmodem_saw_valid_block    = blk;
        sl_block_num              = num;
        step(1);
        xmodem_saw_valid_msg_byte = 1'b0;
        xmodem_saw_valid_block    = 1'b0;
    endtask

    task automatic pulse_done();
        xmodem_done = 1'b1;
        step(1);
        xmodem_done = 1'b0;
    endtask

    task automatic wait_done(input int base, input int max_cycles);
        for (int i = 0; i < max_cycles && done_total == base; i++) step(1);
        step(3);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({sl_wr_valid, sl_wr_addr, sl_wr_data, sl_done, sl_num_words, sl_seq_err, sl_ovf_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b addr=%h data=%h done=%b num=%0d seq=%b ovf=%b expected all 0",
                     sl_wr_valid, sl_wr_addr, sl_wr_data, sl_done, sl_num_words, sl_seq_err, sl_ovf_err);
        end
    endtask

    task automatic test_basic();
        int bw = wr_total;
        int bd = done_total;
        logic [31:0] exp_w [2] = '{32'h04030201, 32'h08070605};
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 1, 8'd0);
        pulse_done();
        wait_done(bd, 100);
        n_checks++;
        if (wr_total - bw != 2) begin
            n_fail++; $display("FAIL basic_count: got %0d writes expected 2", wr_total - bw);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mon_addr[bw+k] !== 25'(k) || mon_data[bw+k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                         k, mon_addr[bw+k], mon_data[bw+k], k, exp_w[k]);
            end
        end
        n_checks++;
        if (sl_num_words !== 25'd2 || sl_seq_err !== 1'b0 || sl_ovf_err !== 1'b0 || done_total - bd != 1) begin
            n_fail++;
            $display("FAIL basic_status: got num=%0d seq=%b ovf=%b done_pulses=%0d expected 2 0 0 1",
                     sl_num_words, sl_seq_err, sl_ovf_err, done_total - bd);
        end
    endtask

    task automatic test_stray_done();
        int bw = wr_total;
        int bd = done_total;
        pulse_done();
        step(10);
        n_checks++;
        if (done_total != bd || wr_total != bw || sl_num_words !== 25'd2) begin
            n_fail++;
            $display("FAIL stray_done: got done_pulses=%0d writes=%0d num=%0d expected 0 0 2",
                     done_total - bd, wr_total - bw, sl_num_words);
        end
    endtask

    task automatic test_partial();
        int bw = wr_total;
        int bd = done_total;
        for (int i = 0; i < 130; i++) send_byte(8'hAA, i == 0 || i == 128, (i == 128) ? 8'd1 : 8'd0);
        pulse_done();
        wait_done(bd, 200);
        n_checks++;
        if (wr_total - bw != 33 || sl_num_words !== 25'd33) begin
            n_fail++;
            $display("FAIL partial_count: got writes=%0d num=%0d expected 33 33", wr_total - bw, sl_num_words);
        end
        n_checks++;
        if (mon_addr[bw+32] !== 25'd32 || mon_data[bw+32] !== 32'h0000AAAA || mon_data[bw] !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL partial_words: got addr32=%h data32=%h data0=%h expected 20 0000aaaa aaaaaaaa",
                     mon_addr[bw+32], mon_data[bw+32], mon_data[bw]);
        end
        n_checks++;
        if (sl_seq_err !== 1'b0 || done_total - bd != 1) begin
            n_fail++;
            $display("FAIL partial_status: got seq=%b done_pulses=%0d expected 0 1", sl_seq_err, done_total - bd);
        end
    endtask

    task automatic test_seq_err();
        int bw = wr_total;
        int bd = done_total;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                n_checks++;
                if (sl_seq_err !== 1'b0) begin
                    n_fail++; $display("FAIL seq_before: got %b expected 0", sl_seq_err);
                end
            end
            send_byte(8'(i), i == 0 || i == 128, (i == 128) ? 8'd2 : 8'd0);
            if (i == 128) begin
                n_checks++;
                if (sl_seq_err !== 1'b1) begin
                    n_fail++; $display("FAIL seq_after: got %b expected 1", sl_seq_err);
                end
            end
        end
        pulse_done();
        wait_done(bd, 200);
        n_checks++;
        if (wr_total - bw != 64 || sl_num_words !== 25'd64 || sl_seq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_count: got writes=%0d num=%0d seq=%b expected 64 64 1",
                     wr_total - bw, sl_num_words, sl_seq_err);
        end
        n_checks++;
        if (mon_data[bw+33] !== 32'h87868584 || mon_addr[bw+63] !== 25'd63) begin
            n_fail++;
            $display("FAIL seq_words: got data33=%h addr63=%h expected 87868584 3f",
                     mon_data[bw+33], mon_addr[bw+63]);
        end
    endtask

    task automatic test_overflow();
        int bw = wr_total;
        int bd = done_total;
        logic [7:0] b0;
        sl_wr_stall = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'(i), i == 0, 8'd0);
        pulse_done();
        step(35);
        n_checks++;
        if (sl_ovf_err !== 1'b1 || sl_wr_valid !== 1'b1 || sl_wr_addr !== 25'd0 || wr_total != bw) begin
            n_fail++;
            $display("FAIL ovf_stalled: got ovf=%b valid=%b addr=%h writes=%0d expected 1 1 0 0",
                     sl_ovf_err, sl_wr_valid, sl_wr_addr, wr_total - bw);
        end
        sl_wr_stall = 1'b0;
        wait_done(bd, 100);
        n_checks++;
        if (wr_total - bw != 8 || sl_num_words !== 25'd8 || done_total - bd != 1) begin
            n_fail++;
            $display("FAIL ovf_count: got writes=%0d num=%0d done_pulses=%0d expected 8 8 1",
                     wr_total - bw, sl_num_words, done_total - bd);
        end
        for (int k = 0; k < 8; k++) begin
            b0 = 8'(4 * k);
            n_checks++;
            if (mon_addr[bw+k] !== 25'(k) || mon_data[bw+k] !== {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got addr=%h data=%h expected addr=%h data=%h", k,
                         mon_addr[bw+k], mon_data[bw+k], k, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            end
        end
    endtask

    task automatic test_stall_toggle();
        int bw = wr_total;
        int bd = done_total;
        int bs = stab_err;
        logic [7:0] b0;
        fork
            begin
                for (int c = 0; c < 120; c++) begin
                    sl_wr_stall = ~sl_wr_stall;
                    step(1);
                end
            end
            begin
                for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i), i == 0, 8'd0);
                pulse_done();
            end
        join
        sl_wr_stall = 1'b0;
        wait_done(bd, 100);
        n_checks++;
        if (wr_total - bw != 8 || sl_num_words !== 25'd8 || sl_ovf_err !== 1'b0 || stab_err != bs) begin
            n_fail++;
            $display("FAIL toggle_status: got writes=%0d num=%0d ovf=%b unstable=%0d expected 8 8 0 0",
                     wr_total - bw, sl_num_words, sl_ovf_err, stab_err - bs);
        end
        for (int k = 0; k < 8; k++) begin
            b0 = 8'h40 + 8'(4 * k);
            n_checks++;
            if (mon_addr[bw+k] !== 25'(k) || mon_data[bw+k] !== {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}) begin
                n_fail++;
                $display("FAIL toggle_word%0d: got addr=%h data=%h expected addr=%h data=%h", k,
                         mon_addr[bw+k], mon_data[bw+k], k, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        int bw;
        int bd;
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i), i == 0, 8'd5);
        n_checks++;
        if (sl_seq_err !== 1'b1) begin
            n_fail++; $display("FAIL mid_seq_pre: got %b expected 1", sl_seq_err);
        end
        #2 rst_b = 1'b0;
        #1;
        n_checks++;
        if ({sl_wr_valid, sl_wr_addr, sl_wr_data, sl_done, sl_num_words, sl_seq_err, sl_ovf_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got valid=%b addr=%h data=%h done=%b num=%0d seq=%b ovf=%b expected all 0",
                     sl_wr_valid, sl_wr_addr, sl_wr_data, sl_done, sl_num_words, sl_seq_err, sl_ovf_err);
        end
        step(2);
        rst_b = 1'b1;
        step(2);
        bw = wr_total;
        bd = done_total;
        send_byte(8'h11, 1'b1, 8'd0);
        send_byte(8'h22, 1'b0, 8'd0);
        send_byte(8'h33, 1'b0, 8'd0);
        send_byte(8'h44, 1'b0, 8'd0);
        pulse_done();
        wait_done(bd, 100);
        n_checks++;
        if (wr_total - bw != 1 || mon_addr[bw] !== 25'd0 || mon_data[bw] !== 32'h44332211 || sl_num_words !== 25'd1) begin
            n_fail++;
            $display("FAIL mid_reload: got writes=%0d addr=%h data=%h num=%0d expected 1 0 44332211 1",
                     wr_total - bw, mon_addr[bw], mon_data[bw], sl_num_words);
        end
    endtask

    initial begin
        rst_b                     = 1'b0;
        xmodem_data_byte          = '0;
        xmodem_saw_valid_msg_byte = 1'b0;
        xmodem_saw_valid_block    = 1'b0;
        sl_block_num              = '0;
        xmodem_done               = 1'b0;
        sl_wr_stall               = 1'b0;
        #12;
        test_reset();
        rst_b = 1'b1;
        step(2);
        test_basic();
        test_stray_done();
        test_partial();
        test_seq_err();
        test_overflow();
        test_stall_toggle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scene_byte_packer.md
Name: scene_byte_packer

Overview:
- Sits directly downstream of the XMODEM receiver in t_minus_15_days, between the UART/XMODEM front end and the SDRAM write port that holds the scene (kd-tree plus primitives).
- Accepts the validated scene byte stream, packs bytes little-endian into 32-bit words and buffers them in a small FIFO.
- Issues sequential valid/stall writes to the memory arbiter and checks block sequencing.
- On transfer end, flushes the partial word, drains the FIFO and pulses a done strobe that enables render_frame.

Parameters:
- BASE_ADDR, 25'h0, SDRAM word address of the first scene word.
- FIFO_DEPTH, 8, word FIFO entries; power of two, at least 2.
- ADDR_W, 25, memory word-address width.
- BLK_W, 8, width of the XMODEM block-number field.

Ports:
- clk  in  1  system clock.
- rst_b  in  1  asynchronous active-low reset.
- xmodem_data_byte  in  8  received message byte.
- xmodem_saw_valid_msg_byte  in  1  byte valid, single-cycle qualifier.
- xmodem_saw_valid_block  in  1  coincides with the first byte of each 128-byte block.
- sl_block_num  in  BLK_W  0-based block number, sampled with xmodem_saw_valid_block.
- xmodem_done  in  1  one-cycle end-of-transfer pulse (EOT).
- sl_wr_valid  out  1  write request to memory.
- sl_wr_addr  out  ADDR_W  word address.
- sl_wr_data  out  32  packed word.
- sl_wr_stall  in  1  memory not accepting; a write transfers when valid & ~stall.
- sl_done  out  1  one-cycle pulse; all words have been written.
- sl_num_words  out  ADDR_W  words written in the last load; held until the next load starts.
- sl_seq_err  out  1  sticky; block-number mismatch.
- sl_ovf_err  out  1  sticky; word dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_b=0): every output is 0, FIFO empty, byte lane = 0, expected block = 0, write address = BASE_ADDR, state IDLE.
- FSM state IDLE:
  - A valid byte moves the FSM to LOAD.
  - That byte is packed in the same cycle.
  - Both sticky errors clear, sl_num_words clears, and the write address reloads to BASE_ADDR.
- FSM state LOAD, byte packing:
  - Each valid byte writes lane L, bits [8L+7:8L]; L then increments mod 4.
  - When lane 3 fills, the word is pushed to the FIFO on the next clock edge (one-cycle latency from byte to FIFO).
  - Unfilled lanes of a new word start at 0.
- FSM state LOAD, block check:
  - When xmodem_saw_valid_block & valid byte, sl_block_num is compared with the expected block (BLK_W bits, wraps 255 to 0).
  - A mismatch sets sl_seq_err.
  - The expected block increments on every block start, matching or not; data is still packed.
- FSM state LOAD, end of transfer:
  - xmodem_done moves LOAD to FLUSH.
  - If L != 0, the partial word is zero-padded and pushed.
  - If a valid byte arrives in the same cycle as xmodem_done, it is packed first and included in the flush.
- FSM state FLUSH: wait until the FIFO is empty and no write is outstanding, then go to DONE.
- FSM state DONE: sl_done=1 for one cycle, sl_num_words is final, next state IDLE.
- Write port:
  - sl_wr_valid = FIFO not empty; sl_wr_data is the FIFO head.
  - sl_wr_addr is the current address.
  - On valid & ~stall: pop the FIFO, increment the address, increment sl_num_words.
  - While stalled, data and address are held stable.
  - The address wraps modulo 2^ADDR_W with no error.
- FIFO boundaries:
  - Push and pop in the same cycle are both permitted when full; the count is unchanged.
  - A push while full with no pop drops the word and sets sl_ovf_err; the address is not advanced for the dropped word.
- Stray and glitch inputs:
  - xmodem_done in IDLE is ignored.
  - Valid bytes during FLUSH or DONE are ignored.
- Reset mid-transfer: everything returns to reset values immediately and any partial word is discarded.

Decomposition:
- Shared package, scene_pkg:
  - scene_word_t (32 bits).
  - sl_state_t enum {SL_IDLE, SL_LOAD, SL_FLUSH, SL_DONE}.
  - XMODEM_BLK_BYTES = 128.
- One sub-module, sl_word_fifo: a synchronous FIFO with parameter DEPTH, providing full/empty/count, push and pop, and simultaneous push/pop when full.

Test Plan:
- Bytes 01 02 03 04 05 06 07 08, block 0 at the first byte, then done -> two writes: addr 0 = 32'h04030201, addr 1 = 32'h08070605; sl_done pulse; sl_num_words = 2; no errors.
- 130 bytes of value 8'hAA, block starts 0 and 1, then done -> 33 writes; word 32 = 32'h0000AAAA; sl_num_words = 33.
- Block numbers 0, 2 at byte 0 and byte 128 -> sl_seq_err=1 after byte 128; all 256 bytes are still written (64 words).
- sl_wr_stall=1 for 100 cycles while streaming 64 bytes with FIFO_DEPTH=8 -> sl_ovf_err=1; addresses stay contiguous with no gaps; words written = 64/4 minus dropped words.
- Stall toggled every other cycle -> sl_wr_data and sl_wr_addr stay stable while stalled; no duplicated or skipped words.
- rst_b low after 6 bytes, then a new 4-byte load -> outputs go to 0 immediately; the new load writes one word at BASE_ADDR; sl_num_words = 1.
